cc_branch_unit: RTL and testbench
=================================

// Module: cc_branch_unit
// PURPOSE
// - LC-3b condition-code and branch-resolve unit in the MEM stage.
// - A 2:1 mux selects the writeback value; gencc derives a one-hot NZP code from it.
// - The CC register holds the code; benable compares the held CC with the NZP field of a BR.
// - Result drives br_en and a pipeline flush.
// PARAMETERS
// - WIDTH  16  data width of the writeback values; NZP sign taken from bit WIDTH-1
// PORTS
// - clk           in   1      rising-edge clock; single clock domain
// - reset         in   1      asynchronous, active-high reset
// - load_cc       in   1      load CC register with gencc result this edge
// - stall         in   1      stage stalled: CC load and counters suppressed
// - src_sel       in   1      0: wb_alu, 1: wb_mem (mux2 select)
// - wb_alu        in   WIDTH  ALU/regfile writeback candidate
// - wb_mem        in   WIDTH  memory-read writeback candidate
// - is_br         in   1      current instruction is BR (opcode 0000, nonzero word)
// - nzp_req       in   3      instruction bits [11:9] {n,z,p}
// - wb_out        out  WIDTH  mux2 output (selected writeback value)
// - gencc_out     out  3      combinational one-hot NZP of wb_out
// - cc_out        out  3      registered CC {n,z,p}
// - br_en         out  1      branch taken
// - flush         out  1      flush younger stages; equals br_en
// - cnt_clr       in   1      synchronous clear of statistics counters (BR_STATS_EN only)
// - br_count      out  16     BR instructions retired (BR_STATS_EN only)
// - br_taken_count out 16     taken BRs (BR_STATS_EN only)
// BEHAVIOUR
// - mux2: wb_out = src_sel ? wb_mem : wb_alu; purely combinational.
// - gencc: wb_out[WIDTH-1]=1 -> 3'b100; wb_out==0 -> 3'b010; else 3'b001.
//   - Result is always exactly one-hot.
// - CC register: reset (async) -> 3'b010.
//   - On posedge, if load_cc & ~stall, cc_out <= gencc_out; else it holds.
// - benable: en = (cc_out[2]&nzp_req[2]) | (cc_out[1]&nzp_req[1]) | (cc_out[0]&nzp_req[0]).
//   - Uses the registered CC only; no bypass of same-cycle gencc.
// - br_en = en & is_br; flush = br_en; both are combinational, zero latency.
// - Valid values during reset: cc_out=010, so BRz and BRnzp are taken and BRnp is not.
// - nzp_req=000 never takes the branch. nzp_req=111 always takes it (CC is one-hot).
// - Simultaneous load_cc and is_br in the same cycle: the branch sees the old CC and the new CC appears next cycle.
// - Reset mid-operation: CC forced to 010 immediately, independent of clk.
// CONFIGURATION
// - BR_STATS_EN defined: two 16-bit counters.
//   - Async reset clears both to 0.
//   - cnt_clr, synchronous, has priority over counting.
//   - While ~stall: br_count += is_br; br_taken_count += br_en.
//   - Counters wrap from FFFF to 0000.
// - BR_STATS_EN undefined: counters, cnt_clr logic and the count outputs are omitted.
//   - Ports are kept and br_count/br_taken_count tie to 16'h0000; cnt_clr is ignored.
// TESTING
// - Reset asserted -> cc_out=010, br_en=0 with is_br=0. Then is_br=1, nzp_req=010 -> br_en=1, flush=1.
// - src_sel=0, wb_alu=16'h8000, load_cc=1, edge -> cc_out=100. Then BRn -> br_en=1; BRzp -> br_en=0.
// - src_sel=1, wb_mem=16'h0000, wb_alu=16'h0005, load_cc, edge -> cc_out=010, since the mux picks wb_mem.
// - load_cc=1 with stall=1, wb_out=16'h0001 -> cc_out unchanged. Drop stall, then edge -> cc_out=001.
// - Same-cycle load_cc (value 0x7FFF) with BRp while CC=010 -> br_en=0 this cycle; BRp next cycle -> br_en=1.
// - BR_STATS_EN: 3 BRs with 2 taken -> br_count=3, br_taken_count=2. cnt_clr -> both 0.
//   - Preload 16'hFFFF then one BR -> 0000.

Source files
------------

// File: rtl/cc_branch_unit.sv
// LC-3b MEM-stage condition-code register and branch resolve.
// Define BR_STATS_EN to build the BR retired/taken statistics counters.
module cc_branch_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_cc,
    input  logic             stall,
    input  logic             src_sel,
    input  logic [WIDTH-1:0] wb_alu,
    input  logic [WIDTH-1:0] wb_mem,
    input  logic             is_br,
    input  logic [2:0]       nzp_req,
    output logic [WIDTH-1:0] wb_out,
    output logic [2:0]       gencc_out,
    output logic [2:0]       cc_out,
    output logic             br_en,
    output logic             flush,
    input  logic             cnt_clr,
    output logic [15:0]      br_count,
    output logic [15:0]      br_taken_count
);

    logic en;

    always_comb begin
        wb_out = src_sel ? wb_mem : wb_alu;
    end

    always_comb begin
        gencc_out = 3'b001;
        if (wb_out[WIDTH-1])
            gencc_out = 3'b100;
        else if (wb_out == '0)
            gencc_out = 3'b010;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cc_out <= 3'b010;
        else if (load_cc && !stall)
            cc_out <= gencc_out;
    end

    // Resolve against the registered CC only: a same-cycle load is seen next cycle.
    always_comb begin
        en    = |(cc_out & nzp_req);
        br_en = en & is_br;
        flush = br_en;
    end

`ifdef BR_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            br_count       <= '0;
            br_taken_count <= '0;
        end else if (cnt_clr) begin
            br_count       <= '0;
            br_taken_count <= '0;
        end else if (!stall) begin
            br_count       <= br_count + {15'd0, is_br};
            br_taken_count <= br_taken_count + {15'd0, br_en};
        end
    end
`else
    logic unused_cnt_clr;

    always_comb begin
        unused_cnt_clr = cnt_clr;
        br_count       = '0;
        br_taken_count = '0;
    end
`endif

endmodule

// File: tb/tb_cc_branch_unit.sv
// Self-checking bench for cc_branch_unit against a behavioural NZP/branch model.
module tb_cc_branch_unit;

    localparam int W = 16;
`ifdef BR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, load_cc, stall, src_sel, is_br, cnt_clr;
    logic [W-1:0]  wb_alu, wb_mem, wb_out;
    logic [2:0]    nzp_req, gencc_out, cc_out;
    logic          br_en, flush;
    logic [15:0]   br_count, br_taken_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference state
    logic [2:0] m_cc;
    int unsigned m_bc, m_btc;

    cc_branch_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .load_cc(load_cc), .stall(stall),
        .src_sel(src_sel), .wb_alu(wb_alu), .wb_mem(wb_mem), .is_br(is_br),
        .nzp_req(nzp_req), .wb_out(wb_out), .gencc_out(gencc_out),
        .cc_out(cc_out), .br_en(br_en), .flush(flush), .cnt_clr(cnt_clr),
        .br_count(br_count), .br_taken_count(br_taken_count)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] cc_of(input logic [W-1:0] v);
        int signed s;
        s = $signed(v);
        if (s < 0)  return 3'b100;
        if (s == 0) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic taken_of(input logic [2:0] cc, input logic [2:0] nzp, input logic br);
        return br && ((cc & nzp) != 3'b000);
    endfunction

    // Clock one edge and advance the model from the inputs held across it.
    task automatic tick();
        logic [W-1:0] v;
        logic         t;
        v = src_sel ? wb_mem : wb_alu;
        t = taken_of(m_cc, nzp_req, is_br);
        @(posedge clk);
        if (cnt_clr) begin
            m_bc = 0; m_btc = 0;
        end else if (!stall) begin
            m_bc  = (m_bc + (is_br ? 1 : 0)) % 65536;
            m_btc = (m_btc + (t ? 1 : 0)) % 65536;
        end
        if (load_cc && !stall) m_cc = cc_of(v);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        load_cc = 0; stall = 0; src_sel = 0; is_br = 0; cnt_clr = 0;
        wb_alu = '0; wb_mem = '0; nzp_req = 3'b000;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        m_cc = 3'b010; m_bc = 0; m_btc = 0;
        #1;
        n_checks++; if (cc_out !== 3'b010) begin n_fail++; $display("FAIL reset_cc got %b exp 010", cc_out); end
        n_checks++; if (br_en !== 1'b0) begin n_fail++; $display("FAIL reset_bren got %b exp 0", br_en); end
        is_br = 1; nzp_req = 3'b010; #1;
        n_checks++; if (br_en !== 1'b1 || flush !== 1'b1) begin n_fail++; $display("FAIL reset_brz got br_en=%b flush=%b exp 1,1", br_en, flush); end
        nzp_req = 3'b111; #1;
        n_checks++; if (br_en !== 1'b1) begin n_fail++; $display("FAIL reset_brnzp got %b exp 1", br_en); end
        nzp_req = 3'b101; #1;
        n_checks++; if (br_en !== 1'b0) begin n_fail++; $display("FAIL reset_brnp got %b exp 0", br_en); end
        n_checks++; if (br_count !== 16'h0 || br_taken_count !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h/%h exp 0/0", br_count, br_taken_count); end
        @(negedge clk); reset = 0; idle_inputs(); @(negedge clk);
    endtask

    task automatic test_load_neg();
        idle_inputs(); wb_alu = 16'h8000; load_cc = 1; tick(); load_cc = 0; #1;
        n_checks++; if (cc_out !== 3'b100) begin n_fail++; $display("FAIL load_neg_cc got %b exp 100", cc_out); end
        is_br = 1; nzp_req = 3'b100; #1;
        n_checks++; if (br_en !== 1'b1) begin n_fail++; $display("FAIL brn got %b exp 1", br_en); end
        nzp_req = 3'b011; #1;
        n_checks++; if (br_en !== 1'b0) begin n_fail++; $display("FAIL brzp got %b exp 0", br_en); end
        nzp_req = 3'b000; #1;
        n_checks++; if (br_en !== 1'b0) begin n_fail++; $display("FAIL br000 got %b exp 0", br_en); end
        tick(); idle_inputs();
    endtask

    task automatic test_mux_mem();
        idle_inputs(); src_sel = 1; wb_mem = 16'h0000; wb_alu = 16'h0005; load_cc = 1; #1;
        n_checks++; if (wb_out !== 16'h0000 || gencc_out !== 3'b010) begin n_fail++; $display("FAIL mux_mem got wb=%h cc=%b exp 0000/010", wb_out, gencc_out); end
        tick(); idle_inputs(); #1;
        n_checks++; if (cc_out !== 3'b010) begin n_fail++; $display("FAIL mux_mem_cc got %b exp 010", cc_out); end
    endtask

    task automatic test_stall();
        idle_inputs(); wb_alu = 16'h0001; load_cc = 1; stall = 1; tick(); #1;
        n_checks++; if (cc_out !== 3'b010) begin n_fail++; $display("FAIL stall_hold got %b exp 010", cc_out); end
        stall = 0; tick(); idle_inputs(); #1;
        n_checks++; if (cc_out !== 3'b001) begin n_fail++; $display("FAIL stall_release got %b exp 001", cc_out); end
    endtask

    task automatic test_same_cycle();
        idle_inputs(); wb_alu = 16'h0000; load_cc = 1; tick();
        wb_alu = 16'h7FFF; load_cc = 1; is_br = 1; nzp_req = 3'b001; #1;
        n_checks++; if (br_en !== 1'b0) begin n_fail++; $display("FAIL same_cycle_old got %b exp 0", br_en); end
        tick(); load_cc = 0; #1;
        n_checks++; if (br_en !== 1'b1) begin n_fail++; $display("FAIL same_cycle_new got %b exp 1", br_en); end
        tick(); idle_inputs();
    endtask

    task automatic test_async_reset();
        idle_inputs(); wb_alu = 16'hF000; load_cc = 1; tick(); idle_inputs();
        #2 reset = 1; #1;
        n_checks++; if (cc_out !== 3'b010) begin n_fail++; $display("FAIL async_reset got %b exp 010", cc_out); end
        m_cc = 3'b010; m_bc = 0; m_btc = 0;
        @(negedge clk); reset = 0; @(negedge clk);
    endtask

    task automatic test_counters();
        idle_inputs();
        cnt_clr = 1; tick(); cnt_clr = 0;
        // CC=010: BRz taken, BRp not, BRnzp taken
        is_br = 1; nzp_req = 3'b010; tick();
        nzp_req = 3'b001; tick();
        nzp_req = 3'b111; tick();
        is_br = 0; #1;
        n_checks++; if (br_count !== (STATS ? 16'd3 : 16'd0) || br_taken_count !== (STATS ? 16'd2 : 16'd0)) begin
            n_fail++; $display("FAIL cnt_3_2 got %0d/%0d exp %0d/%0d", br_count, br_taken_count, STATS ? 3 : 0, STATS ? 2 : 0);
        end
        cnt_clr = 1; is_br = 1; nzp_req = 3'b111; tick(); idle_inputs(); #1;
        n_checks++; if (br_count !== 16'd0 || br_taken_count !== 16'd0) begin n_fail++; $display("FAIL cnt_clr got %0d/%0d exp 0/0", br_count, br_taken_count); end
`ifdef BR_STATS_EN
        is_br = 1; nzp_req = 3'b010;
        for (int i = 0; i < 65535; i++) tick();
        #1;
        n_checks++; if (br_count !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_ffff got %h exp ffff", br_count); end
        tick(); idle_inputs(); #1;
        n_checks++; if (br_count !== 16'h0000 || br_taken_count !== 16'h0000) begin n_fail++; $display("FAIL cnt_wrap got %h/%h exp 0000/0000", br_count, br_taken_count); end
`endif
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        for (int i = 0; i < 400; i++) begin
            load_cc = $urandom_range(0, 1); stall = ($urandom_range(0, 3) == 0);
            src_sel = $urandom_range(0, 1); is_br = $urandom_range(0, 1);
            cnt_clr = ($urandom_range(0, 31) == 0); nzp_req = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: wb_alu = '0;
                1: wb_alu = 16'h8000;
                default: wb_alu = 16'($urandom);
            endcase
            wb_mem = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
            #1;
            v = src_sel ? wb_mem : wb_alu;
            n_checks++; if (wb_out !== v || gencc_out !== cc_of(v)) begin n_fail++; $display("FAIL rnd_mux[%0d] got %h/%b exp %h/%b", i, wb_out, gencc_out, v, cc_of(v)); end
            n_checks++; if (br_en !== taken_of(m_cc, nzp_req, is_br) || flush !== br_en) begin n_fail++; $display("FAIL rnd_br[%0d] got %b/%b exp %b", i, br_en, flush, taken_of(m_cc, nzp_req, is_br)); end
            n_checks++; if (cc_out !== m_cc) begin n_fail++; $display("FAIL rnd_cc[%0d] got %b exp %b", i, cc_out, m_cc); end
            n_checks++; if (br_count !== (STATS ? 16'(m_bc) : 16'd0) || br_taken_count !== (STATS ? 16'(m_btc) : 16'd0)) begin
                n_fail++; $display("FAIL rnd_cnt[%0d] got %0d/%0d exp %0d/%0d", i, br_count, br_taken_count, STATS ? m_bc : 0, STATS ? m_btc : 0);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_load_neg();
        test_mux_mem();
        test_stall();
        test_same_cycle();
        test_async_reset();
        test_counters();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
